// File: rtl/grid_writer.sv
// Writer side of the playfield occupancy bitmap.
// Rasterises draw/erase rectangles one cell per clock; clear-all in one.
module grid_writer #(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [7:0]               x_in,
  input  logic [6:0]               y_in,
  input  logic [3:0]               w_in,
  input  logic [3:0]               h_in,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               wr_count,
  output logic [GRID_W*GRID_H-1:0] grid
);

  localparam int N  = GRID_W * GRID_H;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    CLEAR,
    DONE
  } state_t;

  state_t         state_q;
  logic [N-1:0]   grid_q;
  logic           done_q;
  logic [7:0]     wr_count_q;
  logic [8:0]     cx_q;
  logic [7:0]     cy_q;
  logic [7:0]     y0_q;
  logic [3:0]     w_q;
  logic [3:0]     h_q;
  logic [3:0]     nx_q;
  logic [3:0]     ny_q;
  logic           draw_q;

  logic           in_range_d;
  logic           col_end_d;
  logic           last_d;
  logic [IW-1:0]  idx_d;
  logic           rect_d;

  // Cursor decode: bit address, clipping and end-of-rectangle detection.
  always_comb begin
    in_range_d = (cx_q < 9'(GRID_W)) && (cy_q < 8'(GRID_H));
    idx_d      = IW'(cx_q) * IW'(GRID_H) + IW'(cy_q);
    col_end_d  = (ny_q == h_q - 4'd1);
    last_d     = col_end_d && (nx_q == w_q - 4'd1);
    rect_d     = (w_in != 4'd0) && (h_in != 4'd0);
  end

  // Command FSM with registered bitmap, done pulse and write counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grid_q     <= '0;
      done_q     <= 1'b0;
      wr_count_q <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      nx_q       <= '0;
      ny_q       <= '0;
      draw_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cx_q   <= {1'b0, x_in};
            cy_q   <= {1'b0, y_in};
            y0_q   <= {1'b0, y_in};
            w_q    <= w_in;
            h_q    <= h_in;
            nx_q   <= '0;
            ny_q   <= '0;
            draw_q <= cmd_op[0];
            unique case (cmd_op)
              2'b00, 2'b01: begin
                wr_count_q <= '0;
                if (rect_d) begin
                  state_q <= SCAN;
                end else begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end
              end
              2'b10: state_q <= CLEAR;
              2'b11: begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
        SCAN: begin
          if (in_range_d) begin
            grid_q[idx_d] <= draw_q;
            wr_count_q    <= wr_count_q + 8'd1;
          end
          if (last_d) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (col_end_d) begin
            ny_q <= '0;
            cy_q <= y0_q;
            nx_q <= nx_q + 4'd1;
            cx_q <= cx_q + 9'd1;
          end else begin
            ny_q <= ny_q + 4'd1;
            cy_q <= cy_q + 8'd1;
          end
        end
        CLEAR: begin
          grid_q  <= '0;
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign done      = done_q;
  assign wr_count  = wr_count_q;
  assign grid      = grid_q;

endmodule

// File: tb/tb_grid_writer.sv
// Self-checking bench for grid_writer.
// Directed table, hand sequences and random commands vs a cell model.
module tb_grid_writer;

  localparam int GW = 160;
  localparam int GH = 120;
  localparam int N  = GW * GH;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b11;
  logic [7:0]   x_in = '0;
  logic [6:0]   y_in = '0;
  logic [3:0]   w_in = '0;
  logic [3:0]   h_in = '0;
  logic         busy;
  logic         done;
  logic [7:0]   wr_count;
  logic [N-1:0] grid;

  int total = 0;
  int bad = 0;

  logic [N-1:0] mgrid;
  int           mcnt;

  grid_writer #(.GRID_W(GW), .GRID_H(GH)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .x_in      (x_in),
    .y_in      (y_in),
    .w_in      (w_in),
    .h_in      (h_in),
    .busy      (busy),
    .done      (done),
    .wr_count  (wr_count),
    .grid      (grid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] op;
    logic [7:0] x;
    logic [6:0] y;
    logic [3:0] w;
    logic [3:0] h;
    int         lat;
    int         cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_grid(input string name);
    int diff;
    diff = $countones(grid ^ mgrid);
    total++;
    if (diff != 0) begin
      bad++;
      $display("FAIL %s differing_bits=%0d required=0", name, diff);
    end
  endtask

  // Reference: rectangle semantics straight from the cell rules.
  task automatic model(input logic [1:0] op, input int x, input int y,
                       input int w, input int h);
    if (op == 2'b10) begin
      mgrid = '0;
    end else if (op != 2'b11) begin
      mcnt = 0;
      for (int i = 0; i < w; i++) begin
        for (int j = 0; j < h; j++) begin
          if (x + i < GW && y + j < GH) begin
            mgrid[(x + i) * GH + (y + j)] = op[0];
            mcnt++;
          end
        end
      end
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op, input int w,
                                 input int h);
    if (op == 2'b10) return 1;
    if (op == 2'b11) return 0;
    if (w == 0 || h == 0) return 0;
    return w * h;
  endfunction

  // Issue one command; lat = clock edges after accept before done shows.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] x,
                        input logic [6:0] y, input logic [3:0] w,
                        input logic [3:0] h, output int lat);
    bit ok;
    @(negedge clock);
    check("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    x_in = x;
    y_in = y;
    w_in = w;
    h_in = h;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    check("done_seen", int'(ok), 1);
    model(op, int'(x), int'(y), int'(w), int'(h));
    @(negedge clock);
    check("done_single_pulse", int'(done), 0);
    check("ready_after_done", int'(cmd_ready), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lowc;
    int dones;
    logic [1:0] op;
    logic [7:0] x;
    logic [6:0] y;
    logic [3:0] w;
    logic [3:0] h;

    tbl[0] = '{2'b01, 8'd10,  7'd20,  4'd2,  4'd3,  6,   6};
    tbl[1] = '{2'b01, 8'd158, 7'd118, 4'd4,  4'd4,  16,  4};
    tbl[2] = '{2'b00, 8'd10,  7'd21,  4'd1,  4'd2,  2,   2};
    tbl[3] = '{2'b01, 8'd0,   7'd0,   4'd0,  4'd5,  0,   0};
    tbl[4] = '{2'b11, 8'd3,   7'd3,   4'd3,  4'd3,  0,   0};
    tbl[5] = '{2'b01, 8'd5,   7'd100, 4'd15, 4'd15, 225, 225};
    tbl[6] = '{2'b10, 8'd0,   7'd0,   4'd0,  4'd0,  1,   225};
    tbl[7] = '{2'b01, 8'd150, 7'd110, 4'd15, 4'd15, 225, 100};

    mgrid = '0;
    mcnt = 0;
    #23;
    check_grid("reset_grid");
    check("reset_ready", int'(cmd_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_wr_count", int'(wr_count), 0);
    @(negedge clock);
    resetn = 1'b1;

    for (int k = 0; k < 8; k++) begin
      do_cmd(tbl[k].op, tbl[k].x, tbl[k].y, tbl[k].w, tbl[k].h, lat);
      check($sformatf("tbl%0d_latency", k), lat, tbl[k].lat);
      check($sformatf("tbl%0d_wr_count", k), int'(wr_count), tbl[k].cnt);
      check_grid($sformatf("tbl%0d_grid", k));
      if (k == 0) begin
        check("bit1220", int'(grid[1220]), 1);
        check("bit1342", int'(grid[1342]), 1);
      end
      if (k == 1) check("clip_bit0", int'(grid[0]), 0);
      if (k == 2) begin
        check("erase_bit1221", int'(grid[1221]), 0);
        check("erase_keep1220", int'(grid[1220]), 1);
      end
    end

    // Commands offered while busy must be dropped.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    x_in = 8'd40;
    y_in = 7'd40;
    w_in = 4'd15;
    h_in = 4'd15;
    @(posedge clock);
    #1;
    cmd_op = 2'b10;
    x_in = 8'd0;
    y_in = 7'd0;
    w_in = 4'd1;
    h_in = 4'd1;
    lowc = 0;
    dones = 0;
    for (int i = 0; i < 240; i++) begin
      @(negedge clock);
      if (!cmd_ready) lowc++;
      if (done) begin
        dones++;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    model(2'b01, 40, 40, 15, 15);
    check("hold_ready_low_cycles", lowc, 226);
    check("hold_done_count", dones, 1);
    check("hold_wr_count", int'(wr_count), 225);
    check_grid("hold_grid");

    // Reset in the middle of a scan aborts it.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    x_in = 8'd20;
    y_in = 7'd30;
    w_in = 4'd5;
    h_in = 4'd5;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    mgrid = '0;
    check_grid("midreset_grid");
    check("midreset_ready", int'(cmd_ready), 1);
    check("midreset_wr_count", int'(wr_count), 0);
    @(negedge clock);
    resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("midreset_no_done", dones, 0);
    do_cmd(2'b01, 8'd20, 8'd30, 4'd5, 4'd5, lat);
    check("postreset_latency", lat, 25);
    check("postreset_wr_count", int'(wr_count), 25);
    check_grid("postreset_grid");

    // Random commands against the model.
    for (int r = 0; r < 30; r++) begin
      op = 2'($urandom_range(0, 9) < 4 ? 1 : $urandom_range(0, 3));
      x = 8'($urandom_range(0, 255));
      y = 7'($urandom_range(0, 127));
      w = 4'($urandom_range(0, 15));
      h = 4'($urandom_range(0, 15));
      do_cmd(op, x, y, w, h, lat);
      check($sformatf("rnd%0d_latency", r), lat,
            exp_lat(op, int'(w), int'(h)));
      if (op != 2'b11)
        check($sformatf("rnd%0d_wr_count", r), int'(wr_count), mcnt);
      check_grid($sformatf("rnd%0d_grid", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grid_writer.md
Name: grid_writer

Overview:
- Writer side of the 160x120 playfield occupancy bitmap that collision logic reads.
- Accepts rectangle draw, rectangle erase and clear-all commands through a valid/ready handshake.
- Rectangle commands rasterise one cell per clock into a registered bitmap; bitmap bit index for cell (x,y) is 120*x + y.
- Sits between the game-object controllers (player, enemies, projectiles) and every consumer of the grid.

Parameters:
GRID_W, 160, playfield width in cells (x range 0..GRID_W-1)
GRID_H, 120, playfield height in cells (y range 0..GRID_H-1)

Ports:
clock  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  high when block can accept a command
cmd_op  input  2  00 erase rect, 01 draw rect, 10 clear all, 11 no-op
x_in  input  8  rectangle left column
y_in  input  7  rectangle top row
w_in  input  4  rectangle width in cells, 0..15
h_in  input  4  rectangle height in cells, 0..15
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle pulse on command completion
wr_count  output  8  cells actually modified-or-written by last rectangle command
grid  output  GRID_W*GRID_H  registered occupancy bitmap, bit 120*x+y

Behaviour:
- Reset (async, resetn=0): grid all 0, state IDLE, done 0, wr_count 0, internal counters 0. Reset mid-command aborts it; no done pulse.
- cmd_ready = (state==IDLE); busy = !cmd_ready. Accept on rising edge with cmd_valid & cmd_ready; x_in/y_in/w_in/h_in/cmd_op latched there. cmd_valid while busy is ignored (not queued).
- FSM: IDLE, SCAN, CLEAR, DONE.
- IDLE -> SCAN on accepted op 00/01 with w_in!=0 and h_in!=0; wr_count cleared to 0 at accept.
- IDLE -> DONE on accepted op 00/01 with w_in==0 or h_in==0 (no writes, wr_count 0), or op 11.
- IDLE -> CLEAR on accepted op 10.
- SCAN: cursor (cx,cy) starts at (x_in,y_in); one cell per clock, y inner loop (cy increments), x outer (cx increments when cy reaches y_in+h-1, cy reloads y_in). Occupies exactly w*h cycles; last cell -> DONE.
- Cell write: draw sets bit 120*cx+cy to 1, erase sets it to 0; already-matching bit rewritten, still counted.
- Clipping: cursor arithmetic is 9-bit (x) / 8-bit (y), no wrap; cells with cx>=GRID_W or cy>=GRID_H are skipped (no write, not counted) but still consume their cycle.
- wr_count increments per in-range cell; max 225, no overflow.
- CLEAR: all grid bits 0 in one cycle -> DONE. wr_count unchanged.
- DONE: done=1 for exactly this cycle, then IDLE. cmd_ready low in DONE.
- Timing: accept edge E0; rectangle cells written at edges E1..En (n=w*h); done high during cycle after En; cmd_ready high again after E(n+1). Degenerate/no-op/clear: done high in cycle after E1 (clear) or after E0 (degenerate).
- Bits outside the rectangle are never disturbed.

Test Plan:
- Reset then draw (x=10,y=20,w=2,h=3) -> bits 1220,1221,1222,1340,1341,1342 set, all else 0; done exactly 6 cycles after accept edge; wr_count=6.
- Clip: draw (x=158,y=118,w=4,h=4) -> only (158,118),(158,119),(159,118),(159,119) set; bit 0 and row 0 untouched; wr_count=4; done after 16 scan cycles.
- Erase (x=10,y=21,w=1,h=2) after first test -> bits 1221,1222 cleared, 1220/134x remain; wr_count=2.
- Clear all after several draws -> grid==0 in cycle following accept+1; done one pulse; degenerate w=0 -> done after 1 cycle, wr_count=0, grid unchanged.
- Hold cmd_valid high with different args during a 15x15 scan -> ignored, cmd_ready low 226 cycles, exactly one done.
- Assert resetn=0 mid-scan (after 5 cells) -> grid 0 immediately, no done, cmd_ready high after release; next command executes normally.
